// File: rtl/seq_divider64.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/done handshake.
module seq_divider64 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 dbz,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder
);

  localparam int CW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] COUNT_INIT = CW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] q_sh;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   dvs;
  logic [CW-1:0]      count;

  // The partial remainder stays below the divisor, so only the shifted value
  // needs the extra bit; the difference fits back into WIDTH bits.
  logic [WIDTH:0]     r_shift;
  logic               r_ge;
  logic [WIDTH-1:0]   r_diff;
  logic [WIDTH-1:0]   r_next;
  logic [2*WIDTH-1:0] q_next;

  always_comb begin
    r_shift = {rem_r, q_sh[2*WIDTH-1]};
    r_ge    = (r_shift >= {1'b0, dvs});
    r_diff  = r_shift[WIDTH-1:0] - dvs;
    r_next  = r_ge ? r_diff : r_shift[WIDTH-1:0];
    q_next  = {q_sh[2*WIDTH-2:0], r_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      q_sh      <= '0;
      rem_r     <= '0;
      dvs       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[WIDTH-1:0];
              dbz       <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              q_sh  <= dividend;
              rem_r <= '0;
              dvs   <= divisor;
              count <= COUNT_INIT;
              busy  <= 1'b1;
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          q_sh  <= q_next;
          rem_r <= r_next;
          count <= count - CW'(1);
          if (count == '0) begin
            quotient  <= q_next;
            remainder <= r_next;
            dbz       <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider64.sv
// Bench for seq_divider64: cycle-level arithmetic model checked every cycle,
// plus literal expectations from hand-computed vectors.
module tb_seq_divider64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, dbz;
  logic [63:0] quotient;
  logic [31:0] remainder;

  int compared = 0;
  int mismatched = 0;

  seq_divider64 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .dbz(dbz), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Model: an accepted start either finishes at once (divide by zero) or
  // produces dividend/divisor after 64 edges; reset drops everything.
  logic        m_run = 1'b0;
  int          m_left = 0;
  logic [63:0] m_dd = '0;
  logic [31:0] m_dv = '0;
  logic [63:0] m_q = '0;
  logic [31:0] m_r = '0;
  logic        m_dbz = 1'b0;
  logic        m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_left <= 0; m_q <= '0; m_r <= '0; m_dbz <= 1'b0; m_done <= 1'b0;
    end else if (m_run) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_dbz  <= 1'b0;
        m_q    <= m_dd / {32'd0, m_dv};
        m_r    <= 32'(m_dd % {32'd0, m_dv});
      end else begin
        m_done <= 1'b0;
      end
    end else if (start) begin
      if (divisor == 32'd0) begin
        m_q <= '1; m_r <= dividend[31:0]; m_dbz <= 1'b1; m_done <= 1'b1;
      end else begin
        m_run <= 1'b1; m_left <= 64; m_dd <= dividend; m_dv <= divisor; m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", {63'd0, busy}, {63'd0, m_run});
    chk("done", {63'd0, done}, {63'd0, m_done});
    chk("dbz", {63'd0, dbz}, {63'd0, m_dbz});
    chk("quotient", quotient, m_q);
    chk("remainder", {32'd0, remainder}, {32'd0, m_r});
  end

  task automatic issue(input logic [63:0] dd, input logic [31:0] dv);
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
  endtask

  // Counts edges from the start edge until done; scrambles the operands
  // right after the start edge so only internal copies can be used.
  task automatic wait_done(input int budget, output int edges, output int busy_n);
    edges = 0; busy_n = 0;
    do begin
      @(negedge clk);
      edges++;
      if (busy) busy_n++;
      if (edges == 1) begin
        start = 1'b0; dividend = {$urandom, $urandom}; divisor = $urandom;
      end
    end while (!done && edges < budget);
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int e, b;
    repeat (3) @(negedge clk);
    chk("reset_quotient", quotient, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    // product recovery
    issue(64'd83810205, 32'd6789);
    wait_done(100, e, b);
    chk("prod_latency", 64'(e), 64'd65);
    chk("prod_q", quotient, 64'd12345);
    chk("prod_r", {32'd0, remainder}, 64'd0);
    chk("prod_dbz", {63'd0, dbz}, 64'd0);

    // small remainder, busy width
    repeat (2) @(negedge clk);
    issue(64'd100, 32'd7);
    wait_done(100, e, b);
    chk("small_q", quotient, 64'd14);
    chk("small_r", {32'd0, remainder}, 64'd2);
    chk("small_busy_cycles", 64'(b), 64'd64);

    // extremes
    issue(64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF);
    wait_done(100, e, b);
    chk("ext_q", quotient, 64'h00000001_00000001);
    chk("ext_r", {32'd0, remainder}, 64'd0);
    @(negedge clk);
    issue(64'hFFFFFFFF_FFFFFFFF, 32'd1);
    wait_done(100, e, b);
    chk("ext1_q", quotient, 64'hFFFFFFFF_FFFFFFFF);
    chk("ext1_r", {32'd0, remainder}, 64'd0);

    // divide by zero
    @(negedge clk);
    issue(64'd5, 32'd0);
    wait_done(10, e, b);
    chk("dbz_latency", 64'(e), 64'd1);
    chk("dbz_flag", {63'd0, dbz}, 64'd1);
    chk("dbz_q", quotient, 64'hFFFFFFFF_FFFFFFFF);
    chk("dbz_r", {32'd0, remainder}, 64'd5);
    chk("dbz_busy", 64'(b), 64'd0);

    // back-to-back divide by zero keeps done high
    start = 1'b1; dividend = 64'd77; divisor = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("dbz2_done", {63'd0, done}, 64'd1);
    chk("dbz2_r", {32'd0, remainder}, 64'd77);

    // ignored start mid-RUN, then back-to-back from DONE
    @(negedge clk);
    issue(64'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 64'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    e = 11;
    while (!done && e < 100) begin
      @(negedge clk);
      e++;
    end
    chk("ign_latency", 64'(e), 64'd65);
    chk("ign_q", quotient, 64'd14);
    chk("ign_r", {32'd0, remainder}, 64'd2);
    start = 1'b1; dividend = 64'd9; divisor = 32'd3;
    wait_done(100, e, b);
    chk("b2b_latency", 64'(e), 64'd65);
    chk("b2b_q", quotient, 64'd3);
    chk("b2b_r", {32'd0, remainder}, 64'd0);

    // reset mid-operation
    @(negedge clk);
    issue(64'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", {32'd0, remainder}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_idle_busy", {63'd0, busy}, 64'd0);
    issue(64'd100, 32'd7);
    wait_done(100, e, b);
    chk("rst_after_latency", 64'(e), 64'd65);
    chk("rst_after_q", quotient, 64'd14);
    chk("rst_after_r", {32'd0, remainder}, 64'd2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
